// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus with a one-stage broadcast register.
// Optional saturating statistics counters are built when CDB_ARB_STATS_EN is defined.
module cdb_arbiter #(
  parameter int unsigned data_width = 16,
  parameter int unsigned tag_width  = 3,
  parameter int unsigned num_req    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [num_req-1:0]            req_valid,
  input  logic [num_req*tag_width-1:0]  req_tag,
  input  logic [num_req*data_width-1:0] req_value,
  output logic [num_req-1:0]            grant,
  output logic                          cdb_valid,
  output logic [tag_width-1:0]          cdb_tag,
  output logic [data_width-1:0]         cdb_value,
  output logic [15:0]                   stat_bcast,
  output logic [15:0]                   stat_conflict
);

  localparam int unsigned PW = (num_req > 1) ? $clog2(num_req) : 1;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [tag_width-1:0]  cdb_tag_q, cdb_tag_d;
  logic [data_width-1:0] cdb_value_q, cdb_value_d;

  logic [num_req-1:0]    req_rot;
  logic [num_req-1:0]    gnt_rot;
  logic                  found;
  logic [tag_width-1:0]  sel_tag;
  logic [data_width-1:0] sel_value;
  logic [PW-1:0]         nxt_ptr;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    req_rot = num_req'({req_valid, req_valid} >> rr_ptr_q);
    gnt_rot = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < num_req; k++) begin
      if (req_rot[k] && !found) begin
        gnt_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (!reset && !flush) begin
      grant = num_req'(({gnt_rot, gnt_rot} << rr_ptr_q) >> num_req);
    end
  end

  always_comb begin
    sel_tag   = '0;
    sel_value = '0;
    nxt_ptr   = '0;
    for (int unsigned i = 0; i < num_req; i++) begin
      if (grant[i]) begin
        sel_tag   |= req_tag[i*tag_width +: tag_width];
        sel_value |= req_value[i*data_width +: data_width];
        nxt_ptr    = (i == num_req - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    if (flush) begin
      rr_ptr_d = '0;
    end else if (|grant) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = sel_tag;
      cdb_value_d = sel_value;
      rr_ptr_d    = nxt_ptr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_value = cdb_value_q;

`ifdef CDB_ARB_STATS_EN
  logic [15:0] stat_bcast_q, stat_bcast_d;
  logic [15:0] stat_conflict_q, stat_conflict_d;
  logic        contended;

  // Flush suppresses conflict counting but never clears the counters.
  always_comb begin
    contended       = ($countones(req_valid) > 1) && !flush;
    stat_bcast_d    = stat_bcast_q;
    stat_conflict_d = stat_conflict_q;
    if (|grant && stat_bcast_q != '1) begin
      stat_bcast_d = stat_bcast_q + 16'd1;
    end
    if (contended && stat_conflict_q != '1) begin
      stat_conflict_d = stat_conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_bcast_q    <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_bcast_q    <= stat_bcast_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_bcast    = stat_bcast_q;
  assign stat_conflict = stat_conflict_q;
`else
  assign stat_bcast    = '0;
  assign stat_conflict = '0;
`endif

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model checked every negedge plus directed literal checks.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 3;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_value = '0;
  logic [N-1:0]    grant;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_value;
  logic [15:0]     stat_bcast;
  logic [15:0]     stat_conflict;

  cdb_arbiter #(.data_width(DW), .tag_width(TW), .num_req(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_value    (req_value),
    .grant        (grant),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_value    (cdb_value),
    .stat_bcast   (stat_bcast),
    .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pointer as an integer, winner found by a modular priority search.
  int            m_rr = 0;
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_value = '0;
  int            m_bcast = 0;
  int            m_conf = 0;
  int            m_w;

  function automatic int winner();
    if (reset || flush) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    int w;
    w = winner();
    if (w < 0) return '0;
    return N'(1 << w);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rr = 0; m_valid = 1'b0; m_tag = '0; m_value = '0; m_bcast = 0; m_conf = 0;
    end else begin
      m_w = winner();
      if ($countones(req_valid) >= 2 && !flush && m_conf < 65535) m_conf++;
      if (m_w >= 0) begin
        m_valid = 1'b1;
        m_tag   = req_tag[m_w*TW +: TW];
        m_value = req_value[m_w*DW +: DW];
        m_rr    = (m_w + 1) % N;
        if (m_bcast < 65535) m_bcast++;
      end else begin
        m_valid = 1'b0;
        if (flush) m_rr = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("grant", grant, exp_grant());
    check("cdb_valid", cdb_valid, m_valid);
    check("cdb_tag", cdb_tag, m_tag);
    check("cdb_value", cdb_value, m_value);
`ifdef CDB_ARB_STATS_EN
    check("stat_bcast", stat_bcast, m_bcast);
    check("stat_conflict", stat_conflict, m_conf);
`else
    check("stat_bcast", stat_bcast, 0);
    check("stat_conflict", stat_conflict, 0);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic [TW-1:0] t, input logic [DW-1:0] v);
    req_tag[i*TW +: TW]   = t;
    req_value[i*DW +: DW] = v;
  endtask

  logic [N-1:0] pat [5];

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant, 4'b0000);
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_tag", cdb_tag, 3'd0);
    check("rst_value", cdb_value, 16'h0000);
    reset = 1'b0;

    // Single request, one-cycle broadcast latency
    req_valid = 4'b0001; put(0, 3'd2, 16'h1234);
    #1 check("t1_grant", grant, 4'b0001);
    tick();
    check("t1_valid", cdb_valid, 1'b1);
    check("t1_tag", cdb_tag, 3'd2);
    check("t1_value", cdb_value, 16'h1234);
    req_valid = 4'b0011; put(0, 3'd1, 16'h0101); put(1, 3'd5, 16'h0505);
    #1 check("t1_ptr1", grant, 4'b0010);
    tick();
    check("t1_tag5", cdb_tag, 3'd5);

    // Flush blocks grant, clears valid, resets pointer
    flush = 1'b1; req_valid = 4'b0110; put(2, 3'd6, 16'h0606);
    #1 check("fl_grant", grant, 4'b0000);
    check("fl_old_valid", cdb_valid, 1'b1);
    tick();
    check("fl_valid", cdb_valid, 1'b0);
    flush = 1'b0;
    #1 check("fl_after", grant, 4'b0010);
    tick();
    check("fl_tag", cdb_tag, 3'd5);
    flush = 1'b1; req_valid = 4'b0000;
    tick();
    flush = 1'b0;

    // All four requesting: strict rotation
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) put(i, 3'(4 + i), 16'hA000 + 16'(i));
    for (int k = 0; k < 8; k++) begin
      #1 check("rr_grant", grant, 32'(1 << (k % 4)));
      tick();
      check("rr_tag", cdb_tag, 32'(4 + (k % 4)));
      check("rr_value", cdb_value, 32'(16'hA000 + k % 4));
    end

    // Wrap-around from pointer 3
    req_valid = 4'b0100;
    #1 check("wr_prep", grant, 4'b0100);
    tick();
    req_valid = 4'b1001;
    #1 check("wr_top", grant, 4'b1000);
    tick();
    req_valid = 4'b0001;
    #1 check("wr_zero", grant, 4'b0001);
    tick();
    req_valid = 4'b0011;
    #1 check("wr_ptr1", grant, 4'b0010);
    tick();
    req_valid = 4'b0000;

    // Asynchronous reset between edges
    req_valid = 4'b0001; put(0, 3'd3, 16'hBEEF);
    #1 check("ar_grant", grant, 4'b0001);
    tick();
    check("ar_valid", cdb_valid, 1'b1);
    #1 reset = 1'b1;
    #1 check("ar_drop", cdb_valid, 1'b0);
    check("ar_gnt0", grant, 4'b0000);
    check("ar_tag0", cdb_tag, 3'd0);
    #1 reset = 1'b0; req_valid = 4'b0000;
    tick();

    // Statistics: 5 grants, 3 contended, then a contended flush cycle that must not count
    pat[0] = 4'b0111; pat[1] = 4'b0110; pat[2] = 4'b1100; pat[3] = 4'b0001; pat[4] = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      req_valid = pat[k];
      tick();
    end
    flush = 1'b1; req_valid = 4'b0011;
    tick();
    flush = 1'b0; req_valid = 4'b0000;
    tick();
`ifdef CDB_ARB_STATS_EN
    check("st_bcast", stat_bcast, 16'd5);
    check("st_conf", stat_conflict, 16'd3);
`else
    check("st_bcast", stat_bcast, 16'd0);
    check("st_conf", stat_conflict, 16'd0);
`endif

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
